// File: rtl/sipo_deser_pkg.sv
// sipo_deser_pkg: shared state encoding and default word width for the deserializer.
package sipo_deser_pkg;
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL = 1'b1;
    localparam int DEFAULT_WIDTH = 4;
    typedef enum logic {S_EMPTY = ST_EMPTY, S_FULL = ST_FULL} state_t;
endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: shift register and bit counter; word is the assembled value including the current bit.
module sipo_shift_core import sipo_deser_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] word,
    output logic             word_done
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] sr;
    logic [CW-1:0] cnt;
    always_comb begin
        word = MSB_FIRST ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};
        word_done = sin_valid && (cnt == CW'(WIDTH - 1));
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
            cnt <= '0;
        end else if (sin_valid) begin
            sr <= word;
            cnt <= word_done ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer with a valid/ready output holding register and sticky overrun.
module sipo_deser import sipo_deser_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             ovr_clr
);
    state_t state, state_nxt;
    logic [WIDTH-1:0] word;
    logic word_done, load, ovr_set;
    sipo_shift_core #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_core (
        .clk(clk),
        .reset(reset),
        .sin(sin),
        .sin_valid(sin_valid),
        .word(word),
        .word_done(word_done)
    );
    // A completing word is dropped only when the held word is not being consumed on the same edge.
    always_comb begin
        load = word_done && (state == S_EMPTY || dout_ready);
        ovr_set = word_done && state == S_FULL && !dout_ready;
        state_nxt = word_done ? S_FULL : (state == S_FULL && dout_ready) ? S_EMPTY : state;
        dout_valid = state == S_FULL;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_EMPTY;
            dout <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            dout <= load ? word : dout;
            overrun <= ovr_set ? 1'b1 : ovr_clr ? 1'b0 : overrun;
        end
    end
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed stimulus into MSB-first and LSB-first instances, scoreboard monitor on dout.
module tb_sipo_deser;
    logic clk = 0, reset = 0, sin = 0, sin_valid = 0, dout_ready = 1, ovr_clr = 0;
    logic [3:0] dout_m, dout_l;
    logic dv_m, dv_l, ov_m, ov_l;
    int total = 0, passed = 0;
    logic [3:0] q[2][$];
    logic pend[2] = '{1'b0, 1'b0};
    logic mv;
    logic [3:0] md, me;
    logic [11:0] bits5 = 12'hA5F;
    logic [3:0] w5[3] = '{4'hA, 4'h5, 4'hF};

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .dout(dout_m),
        .dout_valid(dv_m), .dout_ready(dout_ready), .overrun(ov_m), .ovr_clr(ovr_clr));
    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid), .dout(dout_l),
        .dout_valid(dv_l), .dout_ready(dout_ready), .overrun(ov_l), .ovr_clr(ovr_clr));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [3:0] em, input logic [3:0] el);
        q[0].push_back(em);
        q[1].push_back(el);
    endtask

    task automatic send(input logic b);
        sin = b;
        sin_valid = 1;
        @(posedge clk);
        #1;
        sin_valid = 0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) send(w[i]);
    endtask

    task automatic idle(input int n);
        sin_valid = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Each newly presented word (valid rising, or valid right after a handshake) pops one expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mv = i == 0 ? dv_m : dv_l;
            md = i == 0 ? dout_m : dout_l;
            if (!reset) pend[i] = 1'b0;
            else begin
                if (mv && !pend[i]) begin
                    if (q[i].size() == 0) begin
                        total++;
                        $display("FAIL mon_unexpected[%0d]: got %0h expected no word", i, md);
                    end else begin
                        me = q[i].pop_front();
                        chk(i == 0 ? "mon_dout_msb" : "mon_dout_lsb", 32'(md), 32'(me));
                    end
                end
                pend[i] = mv && !dout_ready;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_dout_m", 32'(dout_m), 0);
        chk("rst_dout_l", 32'(dout_l), 0);
        chk("rst_valid", 32'({dv_m, dv_l}), 0);
        chk("rst_ovr", 32'({ov_m, ov_l}), 0);
        @(posedge clk);
        #1;
        reset = 1;
        push(4'b1011, 4'b1101);
        send_word(4'b1011);
        chk("t1_valid", 32'(dv_m), 1);
        chk("t1_dout_m", 32'(dout_m), 32'b1011);
        chk("t1_dout_l", 32'(dout_l), 32'b1101);
        idle(1);
        chk("t1_valid_1cyc", 32'(dv_m), 0);
        chk("t1_dout_hold", 32'(dout_m), 32'b1011);
        push(4'b1001, 4'b1001);
        send(1);
        idle(2);
        send(0);
        send(0);
        chk("t3_no_early", 32'({dv_m, dv_l}), 0);
        idle(1);
        send(1);
        chk("t3_valid", 32'(dv_m), 1);
        chk("t3_dout", 32'(dout_m), 32'b1001);
        idle(1);
        dout_ready = 0;
        push(4'b1011, 4'b1101);
        send_word(4'b1011);
        send_word(4'b0110);
        chk("t4_dout_m", 32'(dout_m), 32'b1011);
        chk("t4_dout_l", 32'(dout_l), 32'b1101);
        chk("t4_ovr", 32'({ov_m, ov_l}), 32'b11);
        chk("t4_valid", 32'(dv_m), 1);
        ovr_clr = 1;
        idle(1);
        ovr_clr = 0;
        chk("t4_ovr_clr", 32'({ov_m, ov_l}), 0);
        chk("t4_dout_after_clr", 32'(dout_m), 32'b1011);
        chk("t4_valid_after_clr", 32'(dv_m), 1);
        send(0);
        send(0);
        send(0);
        ovr_clr = 1;
        send(1);
        ovr_clr = 0;
        chk("t4_set_wins", 32'({ov_m, ov_l}), 32'b11);
        chk("t4_dout_stable", 32'(dout_m), 32'b1011);
        dout_ready = 1;
        idle(1);
        chk("t4_drain", 32'(dv_m), 0);
        push(4'hA, 4'h5);
        push(4'h5, 4'hA);
        push(4'hF, 4'hF);
        for (int k = 1; k <= 12; k++) begin
            send(bits5[12-k]);
            if (k >= 4) begin
                chk("t5_dout", 32'(dout_m), 32'(w5[k/4-1]));
                chk("t5_valid", 32'(dv_m), 32'(k % 4 == 0));
            end
        end
        send(1);
        send(1);
        reset = 0;
        #1;
        chk("t6_rst_dout", 32'({dout_m, dout_l}), 0);
        chk("t6_rst_valid", 32'({dv_m, dv_l}), 0);
        chk("t6_rst_ovr", 32'({ov_m, ov_l}), 0);
        @(posedge clk);
        #1;
        reset = 1;
        push(4'b1100, 4'b0011);
        send_word(4'b1100);
        chk("t6_dout_m", 32'(dout_m), 32'b1100);
        chk("t6_dout_l", 32'(dout_l), 32'b0011);
        idle(3);
        chk("sb_drained", 32'(q[0].size() + q[1].size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
